// File: rtl/audio_byte_packer_if.sv
// Handshake bundles for the audio byte packer.
//
// bytestream  : one byte per write, no backpressure.
//   write  - byte in data is valid this cycle
//   data   - 8-bit payload
//   master drives write/data, slave receives them.
//
// audiostream : one signed 16-bit sample per transfer.
//   write  - sample is valid (driven by master)
//   sample - signed 16-bit sample (driven by master)
//   strobe - sink takes the sample this cycle (driven by slave)

interface bytestream;
  logic       write;
  logic [7:0] data;

  modport master (output write, output data);
  modport slave  (input write, input data);
endinterface

interface audiostream;
  logic               write;
  logic signed [15:0] sample;
  logic               strobe;

  modport master (output write, output sample, input strobe);
  modport slave  (input write, input sample, output strobe);
endinterface

// File: rtl/audio_byte_packer.sv
// audio_byte_packer
//
// Pairs a little-endian byte stream into signed 16-bit samples, buffers
// them in a FIFO and presents them through a single output register to a
// sink that takes one sample per strobe.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous, active-high
//   in       - bytestream slave (write, data)
//   out      - audiostream master (write, sample out; strobe in)
//   flush    - one-cycle pulse, discards all buffered data
//   overflow - sticky: a sample was dropped because the FIFO was full
//   level    - FIFO occupancy, not counting the output register

module audio_byte_packer #(
  parameter int FIFO_DEPTH_LOG2 = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  bytestream.slave                 in,
  audiostream.master               out,
  input  logic                     flush,
  output logic                     overflow,
  output logic [FIFO_DEPTH_LOG2:0] level
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_LEVEL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  logic [15:0]                mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic                       lo_valid;
  logic [7:0]                 lo_byte;

  logic transfer;
  logic full;
  logic pop;
  logic push_req;
  logic push_ok;

  // A pop refills the output register whenever it is empty or being
  // emptied this cycle; a push into a full FIFO only succeeds if a pop
  // frees a slot in the same cycle. Flush suppresses both.
  always_comb begin
    transfer = out.write && out.strobe;
    full     = (level == FULL_LEVEL);
    pop      = !flush && (!out.write || transfer) && (level != '0);
    push_req = !flush && in.write && lo_valid;
    push_ok  = push_req && (!full || pop);
  end

  // Sample storage; the high byte comes straight from the bus, the low
  // byte from the pairing register.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= {in.data, lo_byte};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      lo_valid   <= 1'b0;
      lo_byte    <= '0;
      overflow   <= 1'b0;
      out.write  <= 1'b0;
      out.sample <= '0;
    end else if (flush) begin
      // out.sample deliberately keeps its last value across a flush.
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      lo_valid  <= 1'b0;
      overflow  <= 1'b0;
      out.write <= 1'b0;
    end else begin
      // Every second byte completes a pair, even if the sample is then
      // dropped, so pairing never slips out of alignment.
      if (in.write) begin
        lo_valid <= !lo_valid;
        if (!lo_valid) begin
          lo_byte <= in.data;
        end
      end

      if (push_ok) begin
        wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(1);
      end

      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end

      if (pop) begin
        rd_ptr     <= rd_ptr + FIFO_DEPTH_LOG2'(1);
        out.sample <= mem[rd_ptr];
        out.write  <= 1'b1;
      end else if (transfer) begin
        out.write <= 1'b0;
      end

      case ({push_ok, pop})
        2'b10:   level <= level + (FIFO_DEPTH_LOG2 + 1)'(1);
        2'b01:   level <= level - (FIFO_DEPTH_LOG2 + 1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_byte_packer.sv
// Testbench for audio_byte_packer: each scenario task drives bytes and
// strobes, collects every sample the sink takes, and compares against
// samples predicted from the byte stream and the buffer capacity.

module tb_audio_byte_packer;

  localparam int LOG2     = 5;
  localparam int DEPTH    = 1 << LOG2;
  localparam int CAPACITY = DEPTH + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          overflow;
  logic [LOG2:0] level;

  bytestream  bs ();
  audiostream aud ();

  audio_byte_packer #(.FIFO_DEPTH_LOG2(LOG2)) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (bs),
    .out      (aud),
    .flush    (flush),
    .overflow (overflow),
    .level    (level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [15:0] got_q [$];

  // One clock cycle with the given inputs; samples taken by the sink are
  // recorded. Inputs change and outputs are read 1 time unit after the edge.
  task automatic cycle(input logic w, input logic [7:0] d, input logic s, input logic f);
    bs.write   = w;
    bs.data    = d;
    aud.strobe = s;
    flush      = f;
    if (!reset && !f && aud.write && s) got_q.push_back(aud.sample);
    @(posedge clk);
    #1;
    bs.write   = 1'b0;
    aud.strobe = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic idle(input int n, input logic s);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, s, 1'b0);
  endtask

  task automatic write_bytes(input logic [7:0] b [$], input logic s);
    foreach (b[i]) cycle(1'b1, b[i], s, 1'b0);
  endtask

  function automatic logic [15:0] pair(input logic [7:0] lo, input logic [7:0] hi);
    return {hi, lo};
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
    cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
    reset = 1'b0;
    checks++; if (aud.write !== 1'b0) $display("[TB] FAIL reset_write got %0b want 0", aud.write); else passed++;
    checks++; if (aud.sample !== 16'h0000) $display("[TB] FAIL reset_sample got %h want 0000", aud.sample); else passed++;
    checks++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow got %0b want 0", overflow); else passed++;
    checks++; if (level !== '0) $display("[TB] FAIL reset_level got %0d want 0", level); else passed++;
  endtask

  task automatic test_basic_pairing;
    got_q.delete();
    cycle(1'b1, 8'h34, 1'b1, 1'b0);
    cycle(1'b1, 8'h12, 1'b1, 1'b0);
    checks++; if (aud.write !== 1'b0) $display("[TB] FAIL basic_latency_early got %0b want 0", aud.write); else passed++;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (aud.write !== 1'b1) $display("[TB] FAIL basic_latency got %0b want 1", aud.write); else passed++;
    checks++; if (aud.sample !== 16'h1234) $display("[TB] FAIL basic_first got %h want 1234", aud.sample); else passed++;
    cycle(1'b1, 8'hCD, 1'b1, 1'b0);
    cycle(1'b1, 8'hAB, 1'b1, 1'b0);
    idle(4, 1'b1);
    checks++; if (got_q.size() !== 2) $display("[TB] FAIL basic_count got %0d want 2", got_q.size()); else passed++;
    if (got_q.size() == 2) begin
      checks++; if (got_q[0] !== 16'h1234) $display("[TB] FAIL basic_s0 got %h want 1234", got_q[0]); else passed++;
      checks++; if ($signed(got_q[1]) != -21555) $display("[TB] FAIL basic_s1 got %0d want -21555", $signed(got_q[1])); else passed++;
    end
    checks++; if (overflow !== 1'b0) $display("[TB] FAIL basic_overflow got %0b want 0", overflow); else passed++;
  endtask

  task automatic test_fill_overflow;
    logic [7:0]  b [$];
    logic [15:0] exp_q [$];
    int nsamp = CAPACITY + 3;
    for (int i = 0; i < 2 * nsamp; i++) b.push_back(8'($urandom));
    for (int k = 0; k < nsamp && k < CAPACITY; k++) exp_q.push_back(pair(b[2*k], b[2*k+1]));
    write_bytes(b[0 : 2*CAPACITY-1], 1'b0);
    idle(3, 1'b0);
    checks++; if (level !== (LOG2+1)'(DEPTH)) $display("[TB] FAIL fill_level got %0d want %0d", level, DEPTH); else passed++;
    checks++; if (overflow !== 1'b0) $display("[TB] FAIL fill_no_overflow_yet got %0b want 0", overflow); else passed++;
    checks++; if (aud.write !== 1'b1 || aud.sample !== exp_q[0]) $display("[TB] FAIL fill_head got %0b/%h want 1/%h", aud.write, aud.sample, exp_q[0]); else passed++;
    write_bytes(b[2*CAPACITY : 2*nsamp-1], 1'b0);
    idle(2, 1'b0);
    checks++; if (overflow !== 1'b1) $display("[TB] FAIL fill_overflow got %0b want 1", overflow); else passed++;
    checks++; if (level !== (LOG2+1)'(DEPTH)) $display("[TB] FAIL fill_level_after got %0d want %0d", level, DEPTH); else passed++;
    got_q.delete();
    idle(CAPACITY + 8, 1'b1);
    checks++; if (got_q.size() !== exp_q.size()) $display("[TB] FAIL drain_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL drain_s%0d got %h want %h", i, got_q[i], exp_q[i]); else passed++;
    end
  endtask

  task automatic test_flush_mid_pair;
    checks++; if (overflow !== 1'b1) $display("[TB] FAIL flush_pre_overflow got %0b want 1", overflow); else passed++;
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b1, 1'b1);
    checks++; if (level !== '0) $display("[TB] FAIL flush_level got %0d want 0", level); else passed++;
    checks++; if (overflow !== 1'b0) $display("[TB] FAIL flush_overflow got %0b want 0", overflow); else passed++;
    checks++; if (aud.write !== 1'b0) $display("[TB] FAIL flush_write got %0b want 0", aud.write); else passed++;
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    checks++; if (aud.write !== 1'b0) $display("[TB] FAIL flush_gap1 got %0b want 0", aud.write); else passed++;
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    checks++; if (aud.write !== 1'b0) $display("[TB] FAIL flush_gap2 got %0b want 0", aud.write); else passed++;
    idle(1, 1'b0);
    checks++; if (aud.write !== 1'b1 || aud.sample !== 16'h3322) $display("[TB] FAIL flush_sample got %0b/%h want 1/3322", aud.write, aud.sample); else passed++;
    idle(1, 1'b1);
    checks++; if (aud.write !== 1'b0) $display("[TB] FAIL flush_drained got %0b want 0", aud.write); else passed++;
  endtask

  task automatic test_full_simultaneous;
    logic [7:0]  b [$];
    logic [15:0] exp_q [$];
    for (int i = 0; i < 2 * CAPACITY + 2; i++) b.push_back(8'($urandom));
    for (int k = 0; k < CAPACITY + 1; k++) exp_q.push_back(pair(b[2*k], b[2*k+1]));
    got_q.delete();
    write_bytes(b[0 : 2*CAPACITY-1], 1'b0);
    idle(3, 1'b0);
    checks++; if (level !== (LOG2+1)'(DEPTH)) $display("[TB] FAIL simul_pre_level got %0d want %0d", level, DEPTH); else passed++;
    cycle(1'b1, b[2*CAPACITY], 1'b0, 1'b0);
    cycle(1'b1, b[2*CAPACITY+1], 1'b1, 1'b0);
    checks++; if (level !== (LOG2+1)'(DEPTH)) $display("[TB] FAIL simul_level got %0d want %0d", level, DEPTH); else passed++;
    checks++; if (overflow !== 1'b0) $display("[TB] FAIL simul_overflow got %0b want 0", overflow); else passed++;
    idle(CAPACITY + 8, 1'b1);
    checks++; if (got_q.size() !== exp_q.size()) $display("[TB] FAIL simul_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL simul_s%0d got %h want %h", i, got_q[i], exp_q[i]); else passed++;
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  b [$];
    logic [15:0] exp_q [$];
    for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
    for (int k = 0; k < 10; k++) exp_q.push_back(pair(b[2*k], b[2*k+1]));
    write_bytes(b, 1'b0);
    idle(3, 1'b0);
    got_q.delete();
    idle(10, 1'b1);
    checks++; if (got_q.size() !== 10) $display("[TB] FAIL b2b_count got %0d want 10", got_q.size()); else passed++;
    for (int i = 0; i < 10 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL b2b_s%0d got %h want %h", i, got_q[i], exp_q[i]); else passed++;
    end
    checks++; if (aud.write !== 1'b0) $display("[TB] FAIL b2b_empty got %0b want 0", aud.write); else passed++;
  endtask

  task automatic test_reset_mid_stream;
    logic [7:0] b [$];
    for (int i = 0; i < 21; i++) b.push_back(8'($urandom));
    write_bytes(b, 1'b0);
    idle(3, 1'b0);
    checks++; if (level !== (LOG2+1)'(9)) $display("[TB] FAIL rst_pre_level got %0d want 9", level); else passed++;
    reset = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    checks++; if (aud.write !== 1'b0 || aud.sample !== 16'h0000) $display("[TB] FAIL rst_out got %0b/%h want 0/0000", aud.write, aud.sample); else passed++;
    checks++; if (level !== '0 || overflow !== 1'b0) $display("[TB] FAIL rst_state got %0d/%0b want 0/0", level, overflow); else passed++;
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    cycle(1'b1, 8'h80, 1'b0, 1'b0);
    idle(1, 1'b0);
    checks++; if (aud.write !== 1'b1 || aud.sample !== 16'h8001) $display("[TB] FAIL rst_pair got %0b/%h want 1/8001", aud.write, aud.sample); else passed++;
    idle(1, 1'b1);
  endtask

  task automatic test_pointer_wrap;
    logic [7:0]  b [$];
    logic [15:0] exp_q [$];
    logic [15:0] base = 16'($urandom);
    int idx = 0;
    int cyc = 0;
    logic w;
    for (int k = 0; k < 200; k++) begin
      exp_q.push_back(base + 16'(k));
      b.push_back(exp_q[k][7:0]);
      b.push_back(exp_q[k][15:8]);
    end
    got_q.delete();
    while ((idx < b.size() || got_q.size() < exp_q.size()) && cyc < 5000) begin
      w = (idx < b.size()) && ($urandom_range(0, 1) == 1);
      cycle(w, w ? b[idx] : 8'h00, $urandom_range(0, 3) != 0, 1'b0);
      if (w) idx++;
      cyc++;
    end
    checks++; if (got_q.size() !== exp_q.size()) $display("[TB] FAIL wrap_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("[TB] FAIL wrap_s%0d got %h want %h", i, got_q[i], exp_q[i]); else passed++;
    end
    checks++; if (overflow !== 1'b0) $display("[TB] FAIL wrap_overflow got %0b want 0", overflow); else passed++;
  endtask

  initial begin
    reset      = 1'b1;
    flush      = 1'b0;
    bs.write   = 1'b0;
    bs.data    = 8'h00;
    aud.strobe = 1'b0;
    test_reset();
    test_basic_pairing();
    test_fill_overflow();
    test_flush_mid_pair();
    test_full_simultaneous();
    test_back_to_back();
    test_reset_mid_stream();
    test_pointer_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
